// File: rtl/core_bus_pkg.sv
// Shared types and bus widths for the instruction/data bus arbiter.
package core_bus_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } master_id_e;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  function automatic master_id_e other_master(master_id_e m);
    return (m == MST_INSTR) ? MST_DATA : MST_INSTR;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit master IDs for transactions that are granted but not yet answered.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The caller only pushes into a full FIFO when a pop happens the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one OBI-style slave port between instruction fetch (M0) and data access (M1),
// routing in-order responses back to the issuing master.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIORITY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        protocol_err_o
);

  master_id_e sel;
  master_id_e lock_id_q, lock_id_d;
  master_id_e rr_last_q, rr_last_d;
  logic       lock_valid_q, lock_valid_d;
  logic       prot_err_q, prot_err_d;
  logic       req_sel, handshake;
  logic       fifo_full, fifo_empty, fifo_head, fifo_pop;
  master_id_e head_id;

  always_comb begin
    sel = MST_INSTR;
    if (lock_valid_q) begin
      sel = lock_id_q;
    end else if (data_req_i && !instr_req_i) begin
      sel = MST_DATA;
    end else if (instr_req_i && !data_req_i) begin
      sel = MST_INSTR;
    end else if (instr_req_i && data_req_i) begin
      sel = (DATA_PRIORITY != 0) ? MST_DATA : other_master(rr_last_q);
    end
  end

  assign req_sel   = (sel == MST_DATA) ? data_req_i : instr_req_i;
  // A response this cycle frees a slot, so a full FIFO may still accept a push.
  assign bus_req_o = req_sel & ~(fifo_full & ~bus_rvalid_i);
  assign handshake = bus_req_o & bus_gnt_i;

  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = 4'hF;
    bus_addr_o  = instr_addr_i;
    bus_wdata_o = '0;
    if (sel == MST_DATA) begin
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = handshake & (sel == MST_INSTR);
  assign data_gnt_o  = handshake & (sel == MST_DATA);

  assign fifo_pop = bus_rvalid_i & ~fifo_empty;
  assign head_id  = master_id_e'(fifo_head);

  assign instr_rvalid_o = fifo_pop & (head_id == MST_INSTR);
  assign data_rvalid_o  = fifo_pop & (head_id == MST_DATA);
  assign instr_err_o    = instr_rvalid_o & bus_err_i;
  assign data_err_o     = data_rvalid_o & bus_err_i;
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign protocol_err_o = prot_err_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    rr_last_d    = rr_last_q;
    prot_err_d   = prot_err_q;
    if (handshake) begin
      lock_valid_d = 1'b0;
      rr_last_d    = sel;
    end else if (bus_req_o) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
    if (bus_rvalid_i && fifo_empty) begin
      prot_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= MST_INSTR;
      rr_last_q    <= MST_DATA;
      prot_err_q   <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      rr_last_q    <= rr_last_d;
      prot_err_q   <= prot_err_d;
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (handshake),
    .push_id_i(sel),
    .pop_i    (fifo_pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (fifo_head)
  );

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed scoreboard bench: a fixed-priority instance and a round-robin instance share stimulus.
module tb_core_bus_arbiter;
  import core_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, data_req_i, data_we_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        bus_req_o, bus_we_o, protocol_err_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;

  logic        rr_instr_gnt, rr_instr_rvalid, rr_instr_err;
  logic        rr_data_gnt, rr_data_rvalid, rr_data_err;
  logic [31:0] rr_instr_rdata, rr_data_rdata;
  logic        rr_bus_req, rr_bus_we, rr_perr;
  logic [3:0]  rr_bus_be;
  logic [31:0] rr_bus_addr, rr_bus_wdata;

  int checks   = 0;
  int failures = 0;
  logic rr_mon_en = 1'b0;

  logic [70:0] exp_gnt_q[$];
  logic [67:0] exp_resp_q[$];
  logic [33:0] exp_rr_q[$];

  always #5 clk = ~clk;

  core_bus_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1)) u_dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .protocol_err_o(protocol_err_o)
  );

  core_bus_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_gnt_o(rr_instr_gnt), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(rr_instr_rvalid), .instr_rdata_o(rr_instr_rdata), .instr_err_o(rr_instr_err),
    .data_req_i(data_req_i), .data_gnt_o(rr_data_gnt), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(rr_data_rvalid), .data_rdata_o(rr_data_rdata), .data_err_o(rr_data_err),
    .bus_req_o(rr_bus_req), .bus_gnt_i(bus_gnt_i), .bus_we_o(rr_bus_we), .bus_be_o(rr_bus_be),
    .bus_addr_o(rr_bus_addr), .bus_wdata_o(rr_bus_wdata), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .protocol_err_o(rr_perr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0; instr_addr_i = '0;
    data_req_i   = 1'b0; data_we_i    = 1'b0; data_be_i = 4'h0;
    data_addr_i  = '0;   data_wdata_i = '0;
    bus_gnt_i    = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
  endtask

  // Expected handshake: one-hot grant plus the request fields the slave must see.
  task automatic push_gnt(input logic m, input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    exp_gnt_q.push_back({~m, m, we, be, a, wd});
  endtask

  task automatic push_resp(input logic m, input logic e, input logic [31:0] rd);
    exp_resp_q.push_back({~m, m, ~m & e, m & e, rd, rd});
  endtask

  task automatic push_rr(input logic m, input logic [31:0] a);
    exp_rr_q.push_back({~m, m, a});
  endtask

  // Monitor: compares every handshake and response against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req_o && bus_gnt_i) begin
        if (exp_gnt_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL gnt_unexpected actual_addr=%0h required=none", bus_addr_o);
        end else begin
          chk("gnt", {instr_gnt_o, data_gnt_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o},
              exp_gnt_q.pop_front());
        end
      end else if (instr_gnt_o || data_gnt_o) begin
        checks++; failures++;
        $display("FAIL gnt_spurious actual=%b%b required=00", instr_gnt_o, data_gnt_o);
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        if (exp_resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual=%b%b required=00", instr_rvalid_o, data_rvalid_o);
        end else begin
          chk("resp", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
                       instr_rdata_o, data_rdata_o}, exp_resp_q.pop_front());
        end
      end
      if (rr_mon_en && rr_bus_req && bus_gnt_i) begin
        if (exp_rr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rr_gnt_unexpected actual_addr=%0h required=none", rr_bus_addr);
        end else begin
          chk("rr_gnt", {rr_instr_gnt, rr_data_gnt, rr_bus_addr}, exp_rr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, 5'b0);
    chk("reset_perr", protocol_err_o, 1'b0);
    tick();

    // Single M0 read, granted immediately, answered next cycle.
    instr_req_i = 1'b1; instr_addr_i = 32'h100; bus_gnt_i = 1'b1;
    push_gnt(1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    push_resp(1'b0, 1'b0, 32'hDEADBEEF);
    tick();
    bus_rvalid_i = 1'b0;
    tick();

    // Contest with data priority: M1 write first (error response), then M0.
    instr_req_i = 1'b1; instr_addr_i = 32'h104;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
    data_addr_i = 32'h200; data_wdata_i = 32'hCAFE0001; bus_gnt_i = 1'b1;
    push_gnt(1'b1, 1'b1, 4'h3, 32'h200, 32'hCAFE0001);
    tick();
    data_req_i = 1'b0; data_we_i = 1'b0;
    push_gnt(1'b0, 1'b0, 4'hF, 32'h104, 32'h0);
    bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'h11111111;
    push_resp(1'b1, 1'b1, 32'h11111111);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h22222222;
    push_resp(1'b0, 1'b0, 32'h22222222);
    tick();
    bus_rvalid_i = 1'b0;
    tick();

    // Continuous contest: round-robin alternates from M0, fixed priority keeps M1.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    rr_mon_en = 1'b1;
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    data_req_i = 1'b1; data_addr_i = 32'h400; data_be_i = 4'hC; data_wdata_i = 32'h55;
    bus_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_gnt(1'b1, 1'b0, 4'hC, 32'h400, 32'h55);
      push_rr(i[0], i[0] ? 32'h400 : 32'h300);
      if (i > 0) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h30 + i;
        push_resp(1'b1, 1'b0, 32'h30 + i);
      end
      tick();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h34;
    push_resp(1'b1, 1'b0, 32'h34);
    tick();
    bus_rvalid_i = 1'b0;
    tick();
    chk("rr_order_done", exp_rr_q.size(), 0);

    // Stalled M1 request stays locked while M0 joins; rr instance would otherwise pick M0.
    data_req_i = 1'b1; data_addr_i = 32'h500; data_be_i = 4'hF; data_wdata_i = 32'h0;
    instr_addr_i = 32'h504;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) instr_req_i = 1'b1;
      @(negedge clk);
      chk("stall_addr", bus_addr_o, 32'h500);
      chk("stall_rr_addr", rr_bus_addr, 32'h500);
      chk("stall_req", {bus_req_o, instr_gnt_o, data_gnt_o}, 3'b100);
      tick();
    end
    bus_gnt_i = 1'b1;
    push_gnt(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    push_rr(1'b1, 32'h500);
    tick();
    data_req_i = 1'b0;
    push_gnt(1'b0, 1'b0, 4'hF, 32'h504, 32'h0);
    push_rr(1'b0, 32'h504);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h50;
    push_resp(1'b1, 1'b0, 32'h50);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rdata_i = 32'h51;
    push_resp(1'b0, 1'b0, 32'h51);
    tick();
    bus_rvalid_i = 1'b0;
    tick();
    chk("lock_order_done", exp_rr_q.size(), 0);
    rr_mon_en = 1'b0;

    // Outstanding limit of two: blocked when full, push allowed alongside a pop.
    instr_req_i = 1'b1; instr_addr_i = 32'h600; bus_gnt_i = 1'b1;
    push_gnt(1'b0, 1'b0, 4'hF, 32'h600, 32'h0);
    tick();
    push_gnt(1'b0, 1'b0, 4'hF, 32'h600, 32'h0);
    tick();
    @(negedge clk);
    chk("full_blocks", {bus_req_o, instr_gnt_o}, 2'b00);
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h60;
    push_resp(1'b0, 1'b0, 32'h60);
    push_gnt(1'b0, 1'b0, 4'hF, 32'h600, 32'h0);
    @(negedge clk);
    chk("full_pop_push", {bus_req_o, instr_gnt_o}, 2'b11);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("occupancy_two", bus_req_o, 1'b0);
    tick();
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h61;
    push_resp(1'b0, 1'b0, 32'h61);
    tick();
    bus_rdata_i = 32'h62;
    push_resp(1'b0, 1'b0, 32'h62);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("perr_clean", protocol_err_o, 1'b0);
    tick();

    // Orphan response: no master rvalid, sticky protocol error until reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77;
    @(negedge clk);
    chk("orphan_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    chk("orphan_perr_pre", protocol_err_o, 1'b0);
    tick();
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("perr_set", protocol_err_o, 1'b1);
    tick();
    @(negedge clk);
    chk("perr_held", protocol_err_o, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("perr_cleared", protocol_err_o, 1'b0);
    tick();

    chk("gnt_queue_empty", exp_gnt_q.size(), 0);
    chk("resp_queue_empty", exp_resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares one OBI-style memory port between the core's instruction-fetch master (M0) and data-access master (M1).
- Sits between the core top level and the single-ported system bus/RAM.
- Arbitrates requests, holds the choice stable until the request is granted, and tracks outstanding transactions in order so each rvalid/err goes back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..8); sets the ID FIFO depth.
- DATA_PRIORITY, 1, 1 = M1 (data) always wins a contest; 0 = round-robin between M0 and M1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr_req_i  in  1  M0 request
- instr_gnt_o  out  1  M0 grant
- instr_addr_i  in  32  M0 address (always a read)
- instr_rvalid_o  out  1  M0 response valid
- instr_rdata_o  out  32  M0 read data
- instr_err_o  out  1  M0 response error
- data_req_i  in  1  M1 request
- data_gnt_o  out  1  M1 grant
- data_we_i  in  1  M1 write enable
- data_be_i  in  4  M1 byte enables
- data_addr_i  in  32  M1 address
- data_wdata_i  in  32  M1 write data
- data_rvalid_o  out  1  M1 response valid
- data_rdata_o  out  32  M1 read data
- data_err_o  out  1  M1 response error
- bus_req_o  out  1  slave request
- bus_gnt_i  in  1  slave grant
- bus_we_o  out  1  slave write enable
- bus_be_o  out  4  slave byte enables
- bus_addr_o  out  32  slave address
- bus_wdata_o  out  32  slave write data
- bus_rvalid_i  in  1  slave response valid (slave answers in order)
- bus_rdata_i  in  32  slave read data
- bus_err_i  in  1  slave response error
- protocol_err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- State: lock_valid, lock_id, rr_last (last granted master, round-robin only), ID FIFO (MAX_OUTSTANDING x 1 bit), protocol_err.
- Reset values: FIFO empty, lock_valid=0, lock_id=M0, rr_last=M1 (so M0 wins the first contest), protocol_err_o=0.
- Reset values of the combinational outputs follow from reset state: all gnt/rvalid/err outputs and bus_req_o are 0 unless a master is requesting.
- Selection (combinational):
  - If lock_valid: sel = lock_id.
  - Else if only one master requests: sel = that master.
  - Else if both request: sel = M1 when DATA_PRIORITY=1, otherwise sel = the master other than rr_last.
- Request path, zero latency:
  - bus_req_o = req_sel & ~fifo_full.
  - Address/we/be/wdata are muxed from sel. For M0: bus_we_o=0, bus_be_o=4'hF, bus_wdata_o=0.
  - Grant to the selected master = bus_gnt_i & bus_req_o. The non-selected master's grant is 0.
- Lock: if bus_req_o=1 and bus_gnt_i=0, set lock_valid=1 and lock_id=sel next cycle. Clear it on the cycle the grant occurs. This keeps the OBI rule that an ungranted request stays stable.
- On a handshake (bus_req_o & bus_gnt_i): push sel into the ID FIFO; set rr_last=sel.
- Response path, zero latency: when bus_rvalid_i=1 and the FIFO is not empty:
  - Raise the rvalid of the master at the FIFO head.
  - Pass bus_err_i to that master's err output.
  - Pop the FIFO.
- rdata: instr_rdata_o and data_rdata_o both carry bus_rdata_i unconditionally.
- Simultaneous push and pop in one cycle: occupancy is unchanged. A push into a full FIFO is allowed only when a pop happens in the same cycle. bus_req_o therefore uses fifo_full & ~bus_rvalid_i as its full term.
- FIFO empty with bus_rvalid_i=1: no master rvalid is raised; set protocol_err_o=1 until reset.
- Occupancy counter width is $clog2(MAX_OUTSTANDING+1). Read/write pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: FIFO and lock are cleared. Responses still in flight are then treated as protocol errors; the system must reset the slave together with this block.
- A master dropping req while locked and ungranted violates OBI. The lock stays held until the grant; no recovery is provided.

Decomposition:
- Shared package core_bus_pkg holds:
  - typedef master_id_e {MST_INSTR=1'b0, MST_DATA=1'b1};
  - localparam BUS_AW=32, BUS_DW=32, BUS_BEW=4.
- One sub-module, arb_id_fifo: parameterised depth, 1-bit payload, push/pop/full/empty/head, same clk/rst.

Test Plan:
- Only M0 requests addr 0x100, slave grants the same cycle and rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with instr_rdata_o=0xDEADBEEF in cycle 1; data_rvalid_o stays 0.
- Both request in one cycle, DATA_PRIORITY=1, slave grants every cycle -> M1 granted first, M0 the next cycle; responses return in order M1 then M0.
- DATA_PRIORITY=0, both request continuously for 4 grants -> grant order M0, M1, M0, M1.
- M1 requests while bus_gnt_i is held 0 for 3 cycles and M0 also requests -> bus_addr_o stays at M1's address for all 3 cycles; M1 is granted when bus_gnt_i rises; M0 is granted afterwards.
- MAX_OUTSTANDING=2, two grants with no rvalid -> bus_req_o=0 while full. When an rvalid arrives in the same cycle as a new request, the request is granted that cycle and occupancy stays 2.
- bus_rvalid_i pulsed after reset with no request -> no master rvalid; protocol_err_o=1 and held; rst clears it to 0.
